// File: rtl/gamepad_pkg.sv
// Shared definitions for the game controller poller: sequencer states and
// default timing for a 50 MHz system clock.
package gamepad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        CLK_LO,
        CLK_HI,
        DONE
    } poll_state_t;

    localparam int DEF_CLK_DIV     = 300;
    localparam int DEF_POLL_PERIOD = 833333;
    localparam int DEF_NBITS       = 16;

endpackage

// File: rtl/gamepad_shift.sv
// Per-pad input path: 2-flop synchronizer feeding an LSB-first shift register
// whose parallel output is inverted so that 1 means pressed.
module gamepad_shift
    import gamepad_pkg::*;
#(
    parameter int NBITS = DEF_NBITS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pad_data,
    input  logic             sample_en,
    output logic [NBITS-1:0] word
);

    logic             sync1;
    logic             sync2;
    logic [NBITS-1:0] shift_reg;

    // New bits enter at the top so the first bit shifted ends up in bit 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            shift_reg <= '0;
        end else begin
            sync1 <= pad_data;
            sync2 <= sync1;
            if (sample_en) begin
                shift_reg <= {sync2, shift_reg[NBITS-1:1]};
            end
        end
    end

    assign word = ~shift_reg;

endmodule

// File: rtl/gamepad_poller.sv
// Autonomous poller for two serial game pads: periodic latch/clock sequencing,
// serial capture and registered button snapshots with a sticky new-data flag.
module gamepad_poller
    import gamepad_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int NBITS       = DEF_NBITS
) (
    input  logic             clock,
    input  logic             reset,
    output logic             pad_latch,
    output logic             pad_clk,
    input  logic             pad1_data,
    input  logic             pad2_data,
    output logic [NBITS-1:0] buttons1,
    output logic [NBITS-1:0] buttons2,
    output logic             valid,
    output logic             new_data,
    input  logic             rd_ack,
    output logic [7:0]       poll_count
);

    localparam int TW = $clog2(POLL_PERIOD);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] FINAL_BIT  = BW'(NBITS - 1);

    poll_state_t      state;
    poll_state_t      state_next;
    logic [TW-1:0]    timer;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             poll_req;
    logic             sample_en;
    logic [NBITS-1:0] word1;
    logic [NBITS-1:0] word2;

    assign poll_req = (timer == TIMER_LAST);

    // The period timer free-runs; requests landing outside IDLE are simply lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else begin
            timer <= poll_req ? '0 : timer + TW'(1);
        end
    end

    always_comb begin
        state_next = state;
        sample_en  = 1'b0;
        case (state)
            IDLE: begin
                if (poll_req) state_next = LATCH;
            end
            LATCH: begin
                if (div_cnt == LATCH_LAST) state_next = GAP;
            end
            GAP: begin
                if (div_cnt == HALF_LAST) begin
                    sample_en  = 1'b1;
                    state_next = CLK_LO;
                end
            end
            CLK_LO: begin
                if (div_cnt == HALF_LAST) state_next = CLK_HI;
            end
            CLK_HI: begin
                if (div_cnt == HALF_LAST) begin
                    sample_en  = 1'b1;
                    state_next = (bit_cnt == FINAL_BIT) ? DONE : CLK_LO;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pad strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
        end else begin
            state     <= state_next;
            div_cnt   <= (state_next != state || state == IDLE) ? '0 : div_cnt + DW'(1);
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (sample_en) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            pad_latch <= (state_next == LATCH);
            pad_clk   <= (state_next != CLK_LO);
        end
    end

    // Publishing happens only on completion, so an aborted poll never reaches the outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buttons1   <= '0;
            buttons2   <= '0;
            valid      <= 1'b0;
            new_data   <= 1'b0;
            poll_count <= '0;
        end else begin
            valid <= (state == DONE);
            if (state == DONE) begin
                buttons1   <= word1;
                buttons2   <= word2;
                new_data   <= 1'b1;
                poll_count <= poll_count + 8'd1;
            end else if (rd_ack) begin
                new_data <= 1'b0;
            end
        end
    end

    gamepad_shift #(.NBITS(NBITS)) u_shift1 (
        .clock     (clock),
        .reset     (reset),
        .pad_data  (pad1_data),
        .sample_en (sample_en),
        .word      (word1)
    );

    gamepad_shift #(.NBITS(NBITS)) u_shift2 (
        .clock     (clock),
        .reset     (reset),
        .pad_data  (pad2_data),
        .sample_en (sample_en),
        .word      (word2)
    );

endmodule

// File: tb/tb_gamepad_poller.sv
// Self-checking bench for gamepad_poller: pad models, a poll-schedule reference
// model compared every cycle, and literal checks on key milestones.
module tb_gamepad_poller;

    localparam int CD = 2;
    localparam int PP = 200;
    localparam int NB = 16;
    // Poll offsets counted in clock edges from the edge that enters LATCH.
    localparam int LO_START = 3 * CD;
    localparam int LO_END   = 3 * CD + 2 * CD * (NB - 1);
    localparam int DONE_OFF = LO_END;
    localparam int PUB_OFF  = LO_END + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rd_ack = 1'b0;
    logic          pad1 = 1'b1;
    logic          pad2 = 1'b1;
    logic          pad_latch;
    logic          pad_clk;
    logic [NB-1:0] buttons1;
    logic [NB-1:0] buttons2;
    logic          valid;
    logic          new_data;
    logic [7:0]    poll_count;

    int total = 0;
    int bad   = 0;

    gamepad_poller #(.CLK_DIV(CD), .POLL_PERIOD(PP), .NBITS(NB)) dut (
        .clock      (clock),
        .reset      (reset),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .pad1_data  (pad1),
        .pad2_data  (pad2),
        .buttons1   (buttons1),
        .buttons2   (buttons2),
        .valid      (valid),
        .new_data   (new_data),
        .rd_ack     (rd_ack),
        .poll_count (poll_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pad models: latch loads the pattern and presents bit 0, each pad_clk fall
    // presents the next bit; optional noise right after the fall, settled well
    // before the sample point.
    logic [NB-1:0] cur_pat1 = '0;
    logic [NB-1:0] cur_pat2 = '0;
    logic [NB-1:0] lat1 = '0;
    logic [NB-1:0] lat2 = '0;
    int            bit_idx = 0;
    logic          glitch_en = 1'b0;

    always @(posedge pad_latch) begin
        lat1    = cur_pat1;
        lat2    = cur_pat2;
        bit_idx = 0;
        pad1    = ~lat1[0];
        pad2    = ~lat2[0];
    end

    always @(negedge pad_clk) begin
        bit_idx++;
        if (glitch_en) begin
            #3;
            pad1 = 1'($urandom_range(1));
            pad2 = 1'($urandom_range(1));
            #10;
        end
        pad1 = (bit_idx < NB) ? ~lat1[bit_idx] : 1'b1;
        pad2 = (bit_idx < NB) ? ~lat2[bit_idx] : 1'b1;
    end

    // Reference model: output values after clock edge n since reset release.
    int            n = 0;
    int            off;
    logic          exp_latch = 1'b0;
    logic          exp_clk = 1'b1;
    logic          exp_valid = 1'b0;
    logic          exp_nd = 1'b0;
    logic [7:0]    exp_cnt = '0;
    logic [NB-1:0] exp_b1 = '0;
    logic [NB-1:0] exp_b2 = '0;
    logic [NB-1:0] pend1 = '0;
    logic [NB-1:0] pend2 = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            n = 0;
            exp_latch = 1'b0;
            exp_clk   = 1'b1;
            exp_valid = 1'b0;
            exp_nd    = 1'b0;
            exp_cnt   = '0;
            exp_b1    = '0;
            exp_b2    = '0;
        end else begin
            n++;
            off = n % PP;
            exp_valid = 1'b0;
            if (n >= PP) begin
                exp_latch = (off < 2 * CD);
                exp_clk   = !(off >= LO_START && off < LO_END && ((off - LO_START) % (2 * CD)) < CD);
                if (off == 0) begin
                    pend1 = cur_pat1;
                    pend2 = cur_pat2;
                end
            end else begin
                exp_latch = 1'b0;
                exp_clk   = 1'b1;
            end
            if (n >= PP && off == PUB_OFF) begin
                exp_valid = 1'b1;
                exp_b1    = pend1;
                exp_b2    = pend2;
                exp_nd    = 1'b1;
                exp_cnt   = exp_cnt + 8'd1;
            end else if (rd_ack) begin
                exp_nd = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        check("pad_latch", 32'(pad_latch), 32'(exp_latch));
        check("pad_clk", 32'(pad_clk), 32'(exp_clk));
        check("valid", 32'(valid), 32'(exp_valid));
        check("new_data", 32'(new_data), 32'(exp_nd));
        check("poll_count", 32'(poll_count), 32'(exp_cnt));
        check("buttons1", 32'(buttons1), 32'(exp_b1));
        check("buttons2", 32'(buttons2), 32'(exp_b2));
    end

    int cyc_cnt = 0;
    always @(posedge clock) begin
        if (!reset) cyc_cnt <= 0;
        else        cyc_cnt <= cyc_cnt + 1;
    end

    task automatic wait_valid(output int at);
        int k;
        k  = 0;
        at = -1;
        while (k < 400) begin
            @(posedge clock);
            #1;
            k++;
            if (valid === 1'b1) begin
                at = cyc_cnt;
                return;
            end
        end
        total++;
        bad++;
        $display("[TB] FAIL valid_wait: no valid pulse within %0d cycles", k);
    endtask

    task automatic wait_offset(input int target);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(n >= PP && (n % PP) == target) && k < 500);
        if (k >= 500) begin
            total++;
            bad++;
            $display("[TB] FAIL offset_wait: offset %0d not reached", target);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] p1, input logic [NB-1:0] p2);
        cur_pat1 = p1;
        cur_pat2 = p2;
    endtask

    task automatic checkOutput(input string tag, input logic [NB-1:0] b1, input logic [NB-1:0] b2, input logic [7:0] cnt);
        check({tag, "_b1"}, 32'(buttons1), 32'(b1));
        check({tag, "_b2"}, 32'(buttons2), 32'(b2));
        check({tag, "_cnt"}, 32'(poll_count), 32'(cnt));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int at;
        int last;

        #23;
        checkOutput("reset", '0, '0, 8'd0);
        check("reset_clk", 32'(pad_clk), 32'd1);
        check("reset_latch", 32'(pad_latch), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_nd", 32'(new_data), 32'd0);

        @(negedge clock);
        reset = 1'b1;

        // First poll with disconnected pads
        wait_valid(at);
        check("first_valid_cycle", 32'(at), 32'd267);
        checkOutput("idle_pads", '0, '0, 8'd1);
        check("first_nd", 32'(new_data), 32'd1);
        last = at;

        applyStimulus(16'h5A3C, 16'h0001);
        wait_valid(at);
        check("period_2", 32'(at - last), 32'd200);
        checkOutput("pattern", 16'h5A3C, 16'h0001, 8'd2);
        last = at;

        repeat (10) @(posedge clock);
        @(negedge clock);
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        check("ack_clears", 32'(new_data), 32'd0);

        // Acknowledge landing on the DONE cycle must lose to the set
        applyStimulus(16'hC3A5, 16'h8000);
        wait_offset(DONE_OFF);
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        check("ack_vs_done_valid", 32'(valid), 32'd1);
        check("ack_vs_done_nd", 32'(new_data), 32'd1);
        checkOutput("pattern3", 16'hC3A5, 16'h8000, 8'd3);

        // Abort during the 7th low pulse
        glitch_en = 1'b1;
        applyStimulus(16'(($urandom)), 16'(($urandom)));
        wait_offset(LO_START + 6 * 2 * CD);
        check("abort_in_low", 32'(pad_clk), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort", '0, '0, 8'd0);
        check("abort_clk", 32'(pad_clk), 32'd1);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_nd", 32'(new_data), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // 256 polls with random patterns, noisy pads and random acknowledges
        for (int i = 0; i < 256; i++) begin
            wait_valid(at);
            if (i == 0) check("post_reset_cycle", 32'(at), 32'd267);
            else        check("period", 32'(at - last), 32'd200);
            last = at;
            applyStimulus(16'($urandom), 16'($urandom));
            for (int j = 0; j < 20; j++) begin
                @(negedge clock);
                rd_ack = 1'($urandom_range(1));
            end
            @(negedge clock);
            rd_ack = 1'b0;
        end
        check("count_wrap", 32'(poll_count), 32'd0);

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
